topk_argmax_stream: RTL and testbench

//  Streaming successor to the classifier argmax stage. Accepts IN_SIZE signed class scores one per data_valid

---
 rtl/topk_argmax_stream.sv | 136 +++++++++++++
 tb/tb_topk_argmax_stream.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/topk_argmax_stream.sv
// ============================================================================
// topk_argmax_stream : streaming best/second-best tracker over a score frame
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module topk_argmax_stream #(
  parameter int IN_SIZE    = 10,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 4,
  parameter int TIE_FIRST  = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start_argmax,
  input  logic                         data_valid,
  input  logic signed [DATA_WIDTH-1:0] class_in,
  output logic                         busy,
  output logic                         finish_argmax,
  output logic        [IDX_WIDTH-1:0]  index_out,
  output logic signed [DATA_WIDTH-1:0] max_out,
  output logic        [IDX_WIDTH-1:0]  second_idx,
  output logic        [DATA_WIDTH:0]   margin_out
);

  localparam int CNT_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(IN_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FINISH  = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_next;
  logic                          r_phase;
  logic        [CNT_W-1:0]       r_count;
  logic signed [DATA_WIDTH-1:0]  r_max;
  logic signed [DATA_WIDTH-1:0]  r_second;
  logic        [IDX_WIDTH-1:0]   r_max_idx;
  logic        [IDX_WIDTH-1:0]   r_second_idx;
  logic        [DATA_WIDTH:0]    r_margin;

  logic                          w_accept;
  logic                          w_take;
  logic                          w_beats_max;
  logic                          w_beats_sec;
  logic        [IDX_WIDTH-1:0]   w_k;

  // A start seen during the result pulse is not yet an IDLE-cycle request.
  assign w_accept = (r_state == S_IDLE) && start_argmax && !finish_argmax;
  assign w_take   = (r_state == S_COLLECT) && data_valid;
  assign w_k      = IDX_WIDTH'(r_count);
  assign busy     = (r_state == S_COLLECT) || (r_state == S_FINISH);

  assign w_beats_max = (TIE_FIRST != 0) ? (class_in > r_max)    : (class_in >= r_max);
  assign w_beats_sec = (TIE_FIRST != 0) ? (class_in > r_second) : (class_in >= r_second);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_COLLECT;
      S_COLLECT: if (w_take && (r_count == c_last)) w_next = S_FINISH;
      S_FINISH:  if (r_phase) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Running top-2 update, one beat per cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count      <= '0;
      r_max        <= '0;
      r_second     <= '0;
      r_max_idx    <= '0;
      r_second_idx <= '0;
    end else if (w_accept) begin
      r_count <= '0;
    end else if (w_take) begin
      r_count <= r_count + 1'b1;
      if (r_count == '0) begin
        r_max     <= class_in;
        r_max_idx <= '0;
      end else if (w_beats_max) begin
        r_second     <= r_max;
        r_second_idx <= r_max_idx;
        r_max        <= class_in;
        r_max_idx    <= w_k;
      end else if ((r_count == CNT_W'(1)) || w_beats_sec) begin
        r_second     <= class_in;
        r_second_idx <= w_k;
      end
    end
  end

  // FINISH spans two cycles: margin subtract, then result publish.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase       <= 1'b0;
      r_margin      <= '0;
      finish_argmax <= 1'b0;
      index_out     <= '0;
      max_out       <= '0;
      second_idx    <= '0;
      margin_out    <= '0;
    end else begin
      finish_argmax <= 1'b0;
      if (r_state == S_FINISH) begin
        r_phase <= ~r_phase;
        if (!r_phase) begin
          r_margin <= {r_max[DATA_WIDTH-1], r_max} - {r_second[DATA_WIDTH-1], r_second};
        end else begin
          finish_argmax <= 1'b1;
          index_out     <= r_max_idx;
          max_out       <= r_max;
          second_idx    <= r_second_idx;
          margin_out    <= r_margin;
        end
      end else begin
        r_phase <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_topk_argmax_stream.sv
// ============================================================================
// tb_topk_argmax_stream : directed bench, lowest-index and highest-index tie DUTs
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_topk_argmax_stream;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start_argmax;
  logic               data_valid;
  logic signed [15:0] class_in;

  logic        busy_a, fin_a, busy_b, fin_b;
  logic [3:0]  idx_a, sec_a, idx_b, sec_b;
  logic signed [15:0] max_a, max_b;
  logic [16:0] mar_a, mar_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [15:0] frame [10];

  always #5 clk = ~clk;

  topk_argmax_stream #(.IN_SIZE(10), .DATA_WIDTH(16), .IDX_WIDTH(4), .TIE_FIRST(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start_argmax(start_argmax), .data_valid(data_valid),
    .class_in(class_in), .busy(busy_a), .finish_argmax(fin_a), .index_out(idx_a),
    .max_out(max_a), .second_idx(sec_a), .margin_out(mar_a)
  );

  topk_argmax_stream #(.IN_SIZE(10), .DATA_WIDTH(16), .IDX_WIDTH(4), .TIE_FIRST(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start_argmax(start_argmax), .data_valid(data_valid),
    .class_in(class_in), .busy(busy_b), .finish_argmax(fin_b), .index_out(idx_b),
    .max_out(max_b), .second_idx(sec_b), .margin_out(mar_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_beat(input logic signed [15:0] x);
    data_valid = 1'b1;
    class_in   = x;
    tick;
    data_valid = 1'b0;
  endtask

  // Runs one frame from `frame`; lat = edges from last-beat edge to the pulse.
  task automatic run_frame(input int gap, input int extra, input bit hold, output int lat);
    start_argmax = 1'b1;
    tick;
    start_argmax = hold;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) repeat (gap) tick;
      send_beat(frame[i]);
    end
    check("busy_after_last", {31'b0, busy_a}, 32'd1);
    lat = 0;
    while (!fin_a && lat < 20) begin
      if (lat < extra) begin
        data_valid = 1'b1;
        class_in   = 16'sh7fff;
      end else begin
        data_valid = 1'b0;
      end
      tick;
      lat++;
    end
    data_valid = 1'b0;
    if (!fin_a) check("finish_timeout", 32'd0, 32'd1);
    check("finish_b_aligned", {31'b0, fin_b}, 32'd1);
    check("busy_in_pulse", {31'b0, busy_a}, 32'd0);
  endtask

  task automatic load_s1;
    frame = '{16'sd3, -16'sd1, 16'sd7, 16'sd2, 16'sd7, 16'sd0, -16'sd5, 16'sd1, 16'sd6, 16'sd4};
  endtask

  task automatic check_s1(input string tag);
    check({tag, "_idx_a"}, {28'b0, idx_a}, 32'd2);
    check({tag, "_max_a"}, {16'b0, max_a}, 32'd7);
    check({tag, "_sec_a"}, {28'b0, sec_a}, 32'd4);
    check({tag, "_mar_a"}, {15'b0, mar_a}, 32'd0);
    check({tag, "_idx_b"}, {28'b0, idx_b}, 32'd4);
    check({tag, "_sec_b"}, {28'b0, sec_b}, 32'd2);
    check({tag, "_mar_b"}, {15'b0, mar_b}, 32'd0);
  endtask

  int lat;
  int pulses;

  initial begin
    reset_n      = 1'b0;
    start_argmax = 1'b0;
    data_valid   = 1'b0;
    class_in     = '0;
    repeat (3) tick;
    check("rst_idx", {28'b0, idx_a}, 32'd0);
    check("rst_max", {16'b0, max_a}, 32'd0);
    check("rst_sec", {28'b0, sec_a}, 32'd0);
    check("rst_mar", {15'b0, mar_a}, 32'd0);
    check("rst_busy", {31'b0, busy_a}, 32'd0);
    check("rst_fin", {31'b0, fin_a}, 32'd0);
    reset_n = 1'b1;
    tick;

    // Ties on 7: lowest-index DUT keeps 2, highest-index DUT moves to 4
    load_s1;
    run_frame(0, 0, 1'b0, lat);
    check("t1_latency", lat, 32'd2);
    check_s1("t1");
    tick;
    check("t1_pulse_width", {31'b0, fin_a}, 32'd0);

    // Full-range extremes: margin needs the 17th bit
    for (int i = 0; i < 9; i++) frame[i] = -16'sd32768;
    frame[9] = 16'sd32767;
    run_frame(0, 0, 1'b0, lat);
    check("t3_idx_a", {28'b0, idx_a}, 32'd9);
    check("t3_max_a", {16'b0, max_a}, 32'd32767);
    check("t3_sec_a", {28'b0, sec_a}, 32'd0);
    check("t3_mar_a", {15'b0, mar_a}, 32'd65535);
    check("t3_idx_b", {28'b0, idx_b}, 32'd9);
    check("t3_sec_b", {28'b0, sec_b}, 32'd8);
    check("t3_mar_b", {15'b0, mar_b}, 32'd65535);
    tick;

    // Gapped frame with two trailing 32767 beats that must be ignored
    load_s1;
    run_frame(3, 2, 1'b0, lat);
    check("t4_latency", lat, 32'd2);
    check_s1("t4");
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (fin_a) pulses++;
    end
    check("t4_no_extra_pulse", pulses, 32'd0);
    check_s1("t4_hold");

    // Reset mid-frame after beat 5
    start_argmax = 1'b1;
    tick;
    start_argmax = 1'b0;
    for (int i = 0; i < 6; i++) send_beat(frame[i]);
    reset_n = 1'b0;
    #1;
    check("t5_idx", {28'b0, idx_a}, 32'd0);
    check("t5_max", {16'b0, max_a}, 32'd0);
    check("t5_sec", {28'b0, sec_a}, 32'd0);
    check("t5_mar", {15'b0, mar_b}, 32'd0);
    check("t5_busy", {31'b0, busy_a}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick;
    run_frame(0, 0, 1'b0, lat);
    check("t5_latency", lat, 32'd2);
    check_s1("t5");
    tick;

    // start held high through the frame and the pulse cycle
    run_frame(0, 0, 1'b1, lat);
    check("t6_latency", lat, 32'd2);
    tick;
    check("t6_no_restart_busy", {31'b0, busy_a}, 32'd0);
    start_argmax = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (fin_a || busy_a) pulses++;
    end
    check("t6_single_pulse", pulses, 32'd0);
    check_s1("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
